// File: rtl/ssd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ssd_pkg                                                              |
// | Shared constants and hex segment table for the seven-segment driver. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package ssd_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] ANODE_OFF = 4'hF;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

endpackage
`default_nettype wire

// File: rtl/hex_to_seg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hex_to_seg                                                           |
// | Combinational 4-bit hex digit to active-low seven-segment decoder.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module hex_to_seg
    import ssd_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    assign seg = HEX_SEG[digit];

endmodule
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg7_scan_driver                                                     |
// | Four-digit multiplexed hex display driver with per-frame snapshot,   |
// | per-slot anode guard interval and optional leading-zero blanking.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module seg7_scan_driver
    import ssd_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD       = 4
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] num,
    input  logic        blank_lz,
    output logic [3:0]  H,
    output logic [6:0]  L,
    output logic        frame_done
);

    localparam int             CNT_W     = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_GUARD = CNT_W'(GUARD);

    logic [CNT_W-1:0] cnt;
    logic [1:0]       idx;
    logic [15:0]      snap;
    logic             tick;
    logic             frame_end;

    logic [15:0]      snap_shr;
    logic [3:0]       nibble;
    logic [6:0]       nibble_seg;
    logic             in_guard;
    logic             lz_blank;
    logic [3:0]       h_next;
    logic [6:0]       l_next;

    assign tick      = (cnt == CNT_MAX);
    assign frame_end = tick && (idx == 2'd3);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx <= 2'd0;
        end else if (tick) begin
            idx <= idx + 2'd1;
        end
    end

    // The snapshot is taken on the same edge idx wraps to 0, so a whole
    // frame is always drawn from one captured value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snap       <= 16'h0000;
            frame_done <= 1'b0;
        end else begin
            frame_done <= frame_end;
            if (frame_end) begin
                snap <= num;
            end
        end
    end

    hex_to_seg u_hex_to_seg (
        .digit (nibble),
        .seg   (nibble_seg)
    );

    // snap_shr holds snap[15:4*idx]; zero means this digit is a leading zero.
    always_comb begin
        snap_shr = snap >> {idx, 2'b00};
        nibble   = snap_shr[3:0];
        lz_blank = blank_lz && (idx != 2'd0) && (snap_shr == 16'h0000);
        in_guard = (cnt < CNT_GUARD);
        h_next   = ANODE_OFF;
        if (!in_guard && !lz_blank) begin
            h_next = ~(4'b0001 << idx);
        end
        l_next   = lz_blank ? SEG_BLANK : nibble_seg;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            H <= ANODE_OFF;
            L <= SEG_BLANK;
        end else begin
            H <= h_next;
            L <= l_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_seg7_scan_driver                                                  |
// | Self-checking bench: cycle model plus directed frame checks.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_seg7_scan_driver;

    localparam int RD = 8;
    localparam int GD = 2;
    localparam int FR = 4 * RD;

    localparam logic [6:0] TB_SEG [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] num;
    logic        blank_lz;
    logic [3:0]  H;
    logic [6:0]  L;
    logic        frame_done;

    seg7_scan_driver #(.REFRESH_DIV(RD), .GUARD(GD)) dut (
        .clk        (clk),
        .reset      (reset),
        .num        (num),
        .blank_lz   (blank_lz),
        .H          (H),
        .L          (L),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: m_k edges since reset; slot position and digit follow directly.
    int          m_k;
    int          m_c;
    int          m_d;
    logic [15:0] m_snap;
    logic [15:0] m_up;
    logic        m_bl;
    logic [3:0]  e_h;
    logic [6:0]  e_l;
    logic        e_fd;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_k    = 0;
            m_snap = 16'h0;
            e_h    = 4'hF;
            e_l    = 7'h7F;
            e_fd   = 1'b0;
        end else begin
            m_c  = m_k % RD;
            m_d  = (m_k / RD) % 4;
            m_up = m_snap >> (4 * m_d);
            m_bl = blank_lz && (m_d != 0) && (m_up == 16'h0);
            e_l  = m_bl ? 7'h7F : TB_SEG[m_up[3:0]];
            e_h  = (m_bl || m_c < GD) ? 4'hF : (4'hF & ~(4'h1 << m_d));
            e_fd = (m_c == RD - 1) && (m_d == 3);
            if (e_fd) m_snap = num;
            m_k++;
        end
    end

    logic check_en = 1'b0;

    always @(negedge clk) begin
        if (check_en) begin
            chk("H", 32'(H), 32'(e_h));
            chk("L", 32'(L), 32'(e_l));
            chk("frame_done", 32'(frame_done), 32'(e_fd));
            chk("anode_overlap", 32'($countones(~H) <= 1), 32'd1);
        end
    end

    logic [6:0] fr_seg [4];
    int         fr_lit [4];
    logic [6:0] fr_l   [FR];
    logic [3:0] fr_h   [FR];
    int         fd_pos;
    int         first_lit;

    task automatic run_frame(input int chg_at, input logic [15:0] chg_val);
        for (int d = 0; d < 4; d++) begin
            fr_lit[d] = 0;
            fr_seg[d] = 7'h7F;
        end
        fd_pos    = -1;
        first_lit = -1;
        for (int c = 0; c < FR; c++) begin
            @(negedge clk);
            fr_l[c] = L;
            fr_h[c] = H;
            if (frame_done && fd_pos < 0) fd_pos = c;
            if (H == 4'b1110 && first_lit < 0) first_lit = c;
            for (int d = 0; d < 4; d++) begin
                if (!H[d]) begin
                    fr_lit[d]++;
                    fr_seg[d] = L;
                end
            end
            if (c == chg_at) num = chg_val;
        end
    endtask

    task automatic chk_frame(input string tag, input logic [6:0] s3, input logic [6:0] s2,
                             input logic [6:0] s1, input logic [6:0] s0,
                             input int l3, input int l2, input int l1, input int l0);
        chk({tag, "_seg0"}, 32'(fr_seg[0]), 32'(s0));
        chk({tag, "_seg1"}, 32'(fr_seg[1]), 32'(s1));
        chk({tag, "_seg2"}, 32'(fr_seg[2]), 32'(s2));
        chk({tag, "_seg3"}, 32'(fr_seg[3]), 32'(s3));
        chk({tag, "_lit0"}, 32'(fr_lit[0]), 32'(l0));
        chk({tag, "_lit1"}, 32'(fr_lit[1]), 32'(l1));
        chk({tag, "_lit2"}, 32'(fr_lit[2]), 32'(l2));
        chk({tag, "_lit3"}, 32'(fr_lit[3]), 32'(l3));
        chk({tag, "_fd_pos"}, 32'(fd_pos), 32'(FR - 1));
    endtask

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] SA = 7'b0001000;
    localparam logic [6:0] SF = 7'b0001110;
    localparam logic [6:0] SX = 7'h7F;

    initial begin
        reset    = 1'b1;
        num      = 16'h1234;
        blank_lz = 1'b0;
        repeat (2) @(negedge clk);
        check_en = 1'b1;
        chk("reset_H", 32'(H), 32'hF);
        chk("reset_L", 32'(L), 32'h7F);
        @(negedge clk);
        reset = 1'b0;

        // First frame after release shows the reset snapshot of zero.
        run_frame(-1, 16'h0);
        chk_frame("idle", S0, S0, S0, S0, 6, 6, 6, 6);
        chk("idle_first_lit", 32'(first_lit), 32'(GD));
        chk("idle_guard_H", 32'(fr_h[RD]), 32'hF);

        num = 16'hA5F0;
        run_frame(-1, 16'h0);
        run_frame(-1, 16'h0);
        chk_frame("hex", SA, S5, SF, S0, 6, 6, 6, 6);

        num = 16'h1111;
        run_frame(-1, 16'h0);
        run_frame(RD + 4, 16'h2222);
        chk_frame("tear", S1, S1, S1, S1, 6, 6, 6, 6);
        run_frame(-1, 16'h0);
        chk_frame("tear_next", S2, S2, S2, S2, 6, 6, 6, 6);

        num      = 16'h0030;
        blank_lz = 1'b1;
        run_frame(-1, 16'h0);
        run_frame(-1, 16'h0);
        chk_frame("lz", SX, SX, S3, S0, 0, 0, 6, 6);
        chk("lz_d3_L", 32'(fr_l[3 * RD + 4]), 32'h7F);
        chk("lz_d2_L", 32'(fr_l[2 * RD + 4]), 32'h7F);
        chk("lz_d3_H", 32'(fr_h[3 * RD + 4]), 32'hF);

        num = 16'h0000;
        run_frame(-1, 16'h0);
        run_frame(-1, 16'h0);
        chk_frame("lz_zero", SX, SX, SX, S0, 0, 0, 0, 6);

        blank_lz = 1'b0;
        run_frame(-1, 16'h0);
        chk_frame("nolz_zero", S0, S0, S0, S0, 6, 6, 6, 6);

        // Asynchronous reset between edges during a lit slot.
        repeat (4) @(negedge clk);
        chk("pre_reset_H", 32'(H), 32'hE);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_H", 32'(H), 32'hF);
        chk("async_reset_L", 32'(L), 32'h7F);
        chk("async_reset_fd", 32'(frame_done), 32'h0);
        num = 16'hBEEF;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        run_frame(-1, 16'h0);
        chk_frame("post_reset", S0, S0, S0, S0, 6, 6, 6, 6);
        chk("post_reset_first_lit", 32'(first_lit), 32'(GD));

        for (int i = 0; i < 20 * FR; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) num = 16'($urandom >> $urandom_range(16, 31));
            if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
        end

        @(negedge clk);
        check_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
